// File: rtl/key_scan4.sv
// 4x4 keypad scanner: drives one active-low column at a time, samples the
// rows and accepts a key only after whole-frame press/release debouncing.
module key_scan4 #(
    parameter int SCAN_DIV        = 100000,
    parameter int DEBOUNCE_FRAMES = 20
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    localparam logic [DW-1:0] DIV_LAST  = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_DONE  = CW'(DEBOUNCE_FRAMES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam bit            ONE_FRAME = (DEBOUNCE_FRAMES == 1);

    typedef enum logic [1:0] {
        IDLE,
        DEB_PRESS,
        PRESSED,
        DEB_REL
    } state_t;

    logic [3:0]    row_meta_q;
    logic [3:0]    row_sync_q;

    logic [DW-1:0] div_q;
    logic [DW-1:0] div_d;
    logic [1:0]    col_idx_q;
    logic [1:0]    col_idx_d;
    logic          sample;
    logic          frame_end;

    logic [2:0]    col_zeros;
    logic [1:0]    col_row;
    logic [2:0]    zsum;
    logic [1:0]    ztot;
    logic [3:0]    code_now;
    logic [1:0]    zcnt_q;
    logic [1:0]    zcnt_d;
    logic [3:0]    zcode_q;
    logic [3:0]    zcode_d;

    logic          res_single;
    logic          res_match;

    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_inc;
    logic [3:0]    cand_q;
    logic [3:0]    cand_d;
    logic [3:0]    key_code_q;
    logic [3:0]    key_code_d;
    logic          key_valid_q;
    logic          key_valid_d;
    logic          key_held_q;
    logic          key_held_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_q <= 4'b1111;
            row_sync_q <= 4'b1111;
        end else begin
            row_meta_q <= row_in;
            row_sync_q <= row_meta_q;
        end
    end

    // Rows are read at the last divider count so the column has had the
    // whole slot (minus sync latency) to settle.
    assign sample    = (div_q == DIV_LAST);
    assign frame_end = sample && (col_idx_q == 2'd3);

    always_comb begin
        div_d     = sample ? '0 : div_q + 1'b1;
        col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q     <= '0;
            col_idx_q <= '0;
        end else begin
            div_q     <= div_d;
            col_idx_q <= col_idx_d;
        end
    end

    assign col_out = ~(4'b0001 << col_idx_q);

    always_comb begin
        col_zeros = '0;
        col_row   = '0;
        for (int r = 3; r >= 0; r--) begin
            if (!row_sync_q[r]) begin
                col_zeros = col_zeros + 3'd1;
                col_row   = 2'(r);
            end
        end
    end

    // Zero count saturates at 2: only none/one/many matter.
    always_comb begin
        zsum     = {1'b0, zcnt_q} + col_zeros;
        ztot     = (zsum >= 3'd2) ? 2'd2 : zsum[1:0];
        code_now = (col_zeros == 3'd1) ? {col_idx_q, col_row} : zcode_q;
        zcnt_d   = zcnt_q;
        zcode_d  = zcode_q;
        if (sample) begin
            if (frame_end) begin
                zcnt_d  = '0;
                zcode_d = '0;
            end else begin
                zcnt_d  = ztot;
                zcode_d = code_now;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zcnt_q  <= '0;
            zcode_q <= '0;
        end else begin
            zcnt_q  <= zcnt_d;
            zcode_q <= zcode_d;
        end
    end

    assign res_single = (ztot == 2'd1);
    assign res_match  = res_single && (code_now == key_code_q);
    assign cnt_inc    = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (frame_end) begin
            unique case (state_q)
                IDLE: begin
                    if (res_single) begin
                        cand_d = code_now;
                        if (ONE_FRAME) begin
                            state_d     = PRESSED;
                            cnt_d       = '0;
                            key_code_d  = code_now;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end else begin
                            state_d = DEB_PRESS;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                DEB_PRESS: begin
                    if (res_single && (code_now == cand_q)) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d     = PRESSED;
                            cnt_d       = '0;
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!res_match) begin
                        if (ONE_FRAME) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end else begin
                            state_d = DEB_REL;
                            cnt_d   = CNT_ONE;
                        end
                    end
                end
                DEB_REL: begin
                    if (res_match) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d    = IDLE;
                            cnt_d      = '0;
                            key_held_d = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_key_scan4.sv
// Bench for key_scan4: a keypad model drives the rows from the column
// strobes; expected key codes are queued and checked by a pulse monitor.
module tb_key_scan4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] keys = '0;

    int          n_pass  = 0;
    int          n_total = 0;
    int          n_valid = 0;
    int          v0;
    logic [3:0]  exp_q[$];

    key_scan4 #(
        .SCAN_DIV       (4),
        .DEBOUNCE_FRAMES(3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_in   (row_in),
        .col_out  (col_out),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[c*4+r] && !col_out[c])
                    row_in[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    always @(posedge clk) begin
        #1;
        if (key_valid === 1'b1) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                n_total++;
                $display("FAIL stray key_valid: got code %0d, want no pulse",
                         key_code);
            end else begin
                check("key_code", int'(key_code), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic frames(input int n);
        tick(16 * n);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1;
        check("rst col_out", int'(col_out), 4'b1110);
        check("rst valid", int'(key_valid), 0);
        check("rst held", int'(key_held), 0);
        @(negedge clk);
        rst = 1'b1;
        tick(2);  check("col0", int'(col_out), 4'b1110);
        tick(4);  check("col1", int'(col_out), 4'b1101);
        tick(4);  check("col2", int'(col_out), 4'b1011);
        tick(4);  check("col3", int'(col_out), 4'b0111);
        tick(2);

        // clean press of key 6 (col 1, row 2)
        v0 = n_valid;
        exp_q.push_back(4'd6);
        keys = 16'h0040;
        frames(2); check("p6 early", n_valid, v0);
        frames(1); check("p6 valid", n_valid, v0 + 1);
        check("p6 held", int'(key_held), 1);
        frames(2); check("p6 hold", int'(key_held), 1);
        keys = '0;
        frames(2); check("p6 rel2", int'(key_held), 1);
        frames(1); check("p6 rel3", int'(key_held), 0);
        check("p6 once", n_valid, v0 + 1);

        // bounce on key 10
        v0 = n_valid;
        exp_q.push_back(4'd10);
        keys = 16'h0400; frames(2);
        keys = '0;       frames(1);
        keys = 16'h0400; frames(2);
        check("bnc early", n_valid, v0);
        frames(1); check("bnc valid", n_valid, v0 + 1);
        check("bnc held", int'(key_held), 1);
        frames(1); check("bnc once", n_valid, v0 + 1);
        keys = '0; frames(3);
        check("bnc rel", int'(key_held), 0);

        // keys 0 and 5 together
        v0 = n_valid;
        keys = 16'h0021; frames(6);
        check("multi valid", n_valid, v0);
        check("multi held", int'(key_held), 0);
        keys = '0; frames(1);

        // key change 15 -> 3
        v0 = n_valid;
        exp_q.push_back(4'd15);
        keys = 16'h8000; frames(3);
        check("k15 valid", n_valid, v0 + 1);
        check("k15 held", int'(key_held), 1);
        exp_q.push_back(4'd3);
        keys = 16'h0008;
        frames(2); check("chg held2", int'(key_held), 1);
        frames(1); check("chg held3", int'(key_held), 0);
        frames(2); check("k3 early", n_valid, v0 + 1);
        frames(1); check("k3 valid", n_valid, v0 + 2);
        check("k3 held", int'(key_held), 1);
        keys = '0; frames(3);
        check("k3 rel", int'(key_held), 0);
        check("code kept", int'(key_code), 3);

        // one-frame release glitch on key 9
        v0 = n_valid;
        exp_q.push_back(4'd9);
        keys = 16'h0200; frames(4);
        check("k9 valid", n_valid, v0 + 1);
        keys = '0;       frames(1);
        check("glitch held", int'(key_held), 1);
        keys = 16'h0200; frames(3);
        check("glitch held2", int'(key_held), 1);
        check("glitch once", n_valid, v0 + 1);
        keys = '0; frames(3);
        check("k9 rel", int'(key_held), 0);

        // key 1 held through a reset must re-debounce
        v0 = n_valid;
        exp_q.push_back(4'd1);
        keys = 16'h0002; frames(3);
        check("k1 valid", n_valid, v0 + 1);
        rst = 1'b0;
        #1;
        check("mid rst held", int'(key_held), 0);
        check("mid rst code", int'(key_code), 0);
        check("mid rst col", int'(col_out), 4'b1110);
        exp_q.push_back(4'd1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        frames(2); check("k1 redeb", n_valid, v0 + 1);
        check("k1 redeb held", int'(key_held), 0);
        frames(1); check("k1 again", n_valid, v0 + 2);
        check("k1 held", int'(key_held), 1);
        keys = '0; frames(3);
        check("k1 rel", int'(key_held), 0);

        check("queue empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
